// File: rtl/tlp_fifo_pkg.sv
// Shared definitions for the TLP FIFO reader: FSM states and the layout of the
// sideband bits that sit above the payload in each FIFO word.
package tlp_fifo_pkg;

    localparam int SB_W     = 11;
    localparam int KEEP_LSB = 0;
    localparam int KEEP_W   = 8;
    localparam int SOP_BIT  = 8;
    localparam int EOP_BIT  = 9;
    localparam int ERR_BIT  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/tlp_fifo_reader_sat_cnt.sv
// Saturating statistics counter; a clear wins over a same-cycle increment.
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // count register: clear, saturating increment, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/tlp_fifo_reader.sv
// Pulls TLP beats from a show-ahead FIFO into a one-entry output register,
// dropping orphan beats and closing truncated packets with a terminator beat.
module tlp_fifo_reader
    import tlp_fifo_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic                   clockCore,
    input  logic                   resetCore,
    input  logic                   fifoEmpty,
    input  logic [DATA_W+SB_W-1:0] fifoData,
    output logic                   fifoPop,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_W-1:0]      outData,
    output logic [KEEP_W-1:0]      outKeep,
    output logic                   outSop,
    output logic                   outEop,
    output logic                   outErr,
    input  logic                   enable,
    input  logic                   clrCnt,
    output logic [CNT_W-1:0]       pktCnt,
    output logic [CNT_W-1:0]       dropCnt,
    output logic [CNT_W-1:0]       errCnt,
    output logic                   orphanErr,
    output logic                   busy
);

    state_t r_state;
    state_t w_state_nxt;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [KEEP_W-1:0]   r_out_keep;
    logic                r_out_sop;
    logic                r_out_eop;
    logic                r_out_err;
    logic                r_orphan;

    logic [DATA_W-1:0]   w_data;
    logic [KEEP_W-1:0]   w_keep;
    logic                w_sop;
    logic                w_eop;
    logic                w_err;
    logic                w_free;

    logic                w_pop;
    logic                w_fwd;
    logic                w_term;
    logic                w_orphan;
    logic                w_pkt_inc;
    logic                w_drop_inc;
    logic                w_err_inc;

    assign w_data = fifoData[DATA_W-1:0];
    assign w_keep = fifoData[DATA_W+KEEP_LSB +: KEEP_W];
    assign w_sop  = fifoData[DATA_W+SOP_BIT];
    assign w_eop  = fifoData[DATA_W+EOP_BIT];
    assign w_err  = fifoData[DATA_W+ERR_BIT];
    assign w_free = ~r_out_valid | outReady;

    // state register
    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state decode from the per-cycle actions
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_fwd && !w_eop) begin
                    w_state_nxt = PKT;
                end else if (w_orphan && !w_eop) begin
                    w_state_nxt = DROP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PKT: begin
                if (w_term || (w_fwd && w_eop)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = PKT;
                end
            end
            DROP: begin
                if (w_pop && w_eop) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DROP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // per-cycle actions: pop, forward, terminate, and counter strobes
    always_comb begin
        w_pop      = 1'b0;
        w_fwd      = 1'b0;
        w_term     = 1'b0;
        w_orphan   = 1'b0;
        w_pkt_inc  = 1'b0;
        w_drop_inc = 1'b0;
        w_err_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (fifoEmpty) begin
                    w_pop = 1'b0;
                end else if (!w_sop) begin
                    w_pop      = 1'b1;
                    w_orphan   = 1'b1;
                    w_drop_inc = 1'b1;
                end else if (enable && w_free) begin
                    w_pop     = 1'b1;
                    w_fwd     = 1'b1;
                    w_pkt_inc = w_eop;
                end else begin
                    w_pop = 1'b0;
                end
            end
            PKT: begin
                // a new sop while in a packet means the old one was truncated
                if (fifoEmpty || !w_free) begin
                    w_pop = 1'b0;
                end else if (w_sop) begin
                    w_term    = 1'b1;
                    w_err_inc = 1'b1;
                end else begin
                    w_pop     = 1'b1;
                    w_fwd     = 1'b1;
                    w_pkt_inc = w_eop;
                end
            end
            DROP: begin
                if (fifoEmpty) begin
                    w_pop = 1'b0;
                end else begin
                    w_pop = 1'b1;
                end
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
    end

    // output beat register: load forwarded or terminator beat, else drain on accept
    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_err   <= 1'b0;
        end else if (w_fwd) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_keep  <= w_keep;
            r_out_sop   <= w_sop;
            r_out_eop   <= w_eop;
            r_out_err   <= w_err;
        end else if (w_term) begin
            r_out_valid <= 1'b1;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b1;
            r_out_err   <= 1'b1;
        end else if (outReady) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // orphan pulse, registered one cycle after the offending pop
    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            r_orphan <= 1'b0;
        end else begin
            r_orphan <= w_orphan;
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
        .clk   (clockCore),
        .rst_n (resetCore),
        .inc   (w_pkt_inc),
        .clr   (clrCnt),
        .cnt   (pktCnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clockCore),
        .rst_n (resetCore),
        .inc   (w_drop_inc),
        .clr   (clrCnt),
        .cnt   (dropCnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clockCore),
        .rst_n (resetCore),
        .inc   (w_err_inc),
        .clr   (clrCnt),
        .cnt   (errCnt)
    );

    // the pop strobe is held off while reset is asserted
    assign fifoPop   = w_pop & resetCore;
    assign outValid  = r_out_valid;
    assign outData   = r_out_data;
    assign outKeep   = r_out_keep;
    assign outSop    = r_out_sop;
    assign outEop    = r_out_eop;
    assign outErr    = r_out_err;
    assign orphanErr = r_orphan;
    assign busy      = (r_state != IDLE) | r_out_valid;

endmodule

// File: tb/tb_tlp_fifo_reader.sv
// Directed bench for tlp_fifo_reader: a queue models the FIFO, expected output
// beats go into a scoreboard queue, and a negedge monitor checks accepted beats.
module tb_tlp_fifo_reader;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;
    localparam int W      = DATA_W + 11;

    logic              clockCore = 1'b0;
    logic              resetCore = 1'b0;
    logic              fifoEmpty = 1'b1;
    logic [W-1:0]      fifoData  = '0;
    logic              fifoPop;
    logic              outValid;
    logic              outReady  = 1'b0;
    logic [DATA_W-1:0] outData;
    logic [7:0]        outKeep;
    logic              outSop;
    logic              outEop;
    logic              outErr;
    logic              enable    = 1'b1;
    logic              clrCnt    = 1'b0;
    logic [CNT_W-1:0]  pktCnt;
    logic [CNT_W-1:0]  dropCnt;
    logic [CNT_W-1:0]  errCnt;
    logic              orphanErr;
    logic              busy;

    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int orph_cnt = 0;

    tlp_fifo_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clockCore (clockCore),
        .resetCore (resetCore),
        .fifoEmpty (fifoEmpty),
        .fifoData  (fifoData),
        .fifoPop   (fifoPop),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outKeep   (outKeep),
        .outSop    (outSop),
        .outEop    (outEop),
        .outErr    (outErr),
        .enable    (enable),
        .clrCnt    (clrCnt),
        .pktCnt    (pktCnt),
        .dropCnt   (dropCnt),
        .errCnt    (errCnt),
        .orphanErr (orphanErr),
        .busy      (busy)
    );

    always #5 clockCore = ~clockCore;

    function automatic logic [W-1:0] mk(input logic sop, input logic eop, input logic err,
                                        input logic [7:0] keep, input logic [DATA_W-1:0] data);
        return {err, eop, sop, keep, data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifoEmpty = (fifo_q.size() == 0);
        fifoData  = fifoEmpty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [W-1:0] w, input logic fwd);
        fifo_q.push_back(w);
        if (fwd) exp_q.push_back(w);
        refresh();
    endtask

    // one clock: sample the pop strobe mid-cycle, then retire the head after the edge
    task automatic step();
        logic pop_n;
        @(negedge clockCore);
        pop_n = fifoPop;
        if (pop_n && fifoEmpty) begin
            n_errors++;
            $display("FAIL pop_when_empty: fifoPop=1 with fifoEmpty=1");
        end
        @(posedge clockCore);
        #1;
        if (pop_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !outValid && !busy) && n < 60) begin
            step();
            #1;
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n < 60), 64'd1);
    endtask

    task automatic clear_counters();
        clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
    endtask

    // monitor: scoreboard compare on every accepted beat, stability while stalled
    initial begin
        logic         stall_prev;
        logic [W-1:0] prev_beat;
        logic [W-1:0] cur;
        logic [W-1:0] e;
        stall_prev = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clockCore);
            if (resetCore) begin
                cur = {outErr, outEop, outSop, outKeep, outData};
                if (stall_prev) begin
                    n_checks++;
                    if (!outValid || cur !== prev_beat) begin
                        n_errors++;
                        $display("FAIL hold_stable: got v=%0b %0h expected v=1 %0h", outValid, cur, prev_beat);
                    end
                end
                if (outValid && outReady) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_errors++;
                            $display("FAIL beat: got %0h expected %0h", cur, e);
                        end
                    end
                end
                if (outValid && exp_q.size() == 0 && !outReady) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got outValid=1 expected 0");
                end
                if (orphanErr) orph_cnt++;
                stall_prev = outValid && !outReady;
                prev_beat  = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        // reset state, including no pop while a sop head is present
        fifoEmpty = 1'b0;
        fifoData  = mk(1'b1, 1'b1, 1'b0, 8'hFF, 64'h1);
        repeat (2) @(negedge clockCore);
        chk("rst_pop", 64'(fifoPop), 64'd0);
        chk("rst_valid", 64'(outValid), 64'd0);
        chk("rst_fields", 64'({outKeep, outSop, outEop, outErr} | 11'(outData != '0)), 64'd0);
        chk("rst_cnts", 64'({pktCnt, dropCnt, errCnt}), 64'd0);
        chk("rst_busy_orph", 64'({busy, orphanErr}), 64'd0);
        refresh();
        @(posedge clockCore);
        #1;
        resetCore = 1'b1;
        outReady  = 1'b1;

        // single-beat packet
        push(mk(1'b1, 1'b1, 1'b0, 8'hFF, 64'hAAAA_0000_0000_0001), 1'b1);
        #1;
        chk("single_pop", 64'(fifoPop), 64'd1);
        step();
        #1;
        chk("single_pop_once", 64'(fifoPop), 64'd0);
        chk("single_valid", 64'(outValid), 64'd1);
        chk("single_data", outData, 64'hAAAA_0000_0000_0001);
        drain("single");
        chk("single_pkt", 64'(pktCnt), 64'd1);
        clear_counters();

        // 4-beat packet with back-pressure after beat 2; err passes through on beat 3
        push(mk(1'b1, 1'b0, 1'b0, 8'hFF, 64'hB1), 1'b1);
        push(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'hB2), 1'b1);
        push(mk(1'b0, 1'b0, 1'b1, 8'hFF, 64'hB3), 1'b1);
        push(mk(1'b0, 1'b1, 1'b0, 8'h0F, 64'hB4), 1'b1);
        step();
        step();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_no_pop", 64'(fifoPop), 64'd0);
            chk("bp_hold_b2", outData, 64'hB2);
            step();
        end
        chk("bp_fifo_left", 64'(fifo_q.size()), 64'd2);
        outReady = 1'b1;
        drain("bp");
        chk("bp_pkt", 64'(pktCnt), 64'd1);
        clear_counters();

        // orphan packet dropped with no downstream readiness
        outReady = 1'b0;
        o0 = orph_cnt;
        push(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'hC1), 1'b0);
        push(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'hC2), 1'b0);
        push(mk(1'b0, 1'b1, 1'b0, 8'hFF, 64'hC3), 1'b0);
        repeat (3) step();
        chk("orph_popped", 64'(fifo_q.size()), 64'd0);
        step();
        #1;
        chk("orph_pulses", 64'(orph_cnt - o0), 64'd1);
        chk("orph_drop", 64'(dropCnt), 64'd1);
        chk("orph_idle", 64'({busy, outValid}), 64'd0);
        outReady = 1'b1;
        clear_counters();

        // truncated packet closed by a terminator, then the new packet
        push(mk(1'b1, 1'b0, 1'b0, 8'hFF, 64'hD1), 1'b1);
        push(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'hD2), 1'b1);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 8'h00, 64'h0));
        push(mk(1'b1, 1'b1, 1'b0, 8'h3C, 64'hD3), 1'b1);
        drain("trunc");
        chk("trunc_err", 64'(errCnt), 64'd1);
        chk("trunc_pkt", 64'(pktCnt), 64'd1);
        clear_counters();

        // enable gating: nothing starts, then an in-flight packet completes
        enable = 1'b0;
        push(mk(1'b1, 1'b0, 1'b0, 8'hFF, 64'hE1), 1'b1);
        push(mk(1'b0, 1'b0, 1'b0, 8'hFF, 64'hE2), 1'b1);
        push(mk(1'b0, 1'b1, 1'b0, 8'hFF, 64'hE3), 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("en_no_pop", 64'(fifoPop), 64'd0);
            step();
        end
        enable = 1'b1;
        step();
        enable = 1'b0;
        drain("en");
        chk("en_pkt", 64'(pktCnt), 64'd1);
        enable = 1'b1;
        clear_counters();

        // saturation at 3, then clear beating a same-cycle eop
        for (int i = 0; i < 5; i++) push(mk(1'b1, 1'b1, 1'b0, 8'hFF, 64'(32'hF0 + i)), 1'b1);
        drain("sat");
        chk("sat_pkt", 64'(pktCnt), 64'd3);
        push(mk(1'b1, 1'b1, 1'b0, 8'hFF, 64'hF9), 1'b1);
        clrCnt = 1'b1;
        #1;
        chk("clr_pop_same_cycle", 64'(fifoPop), 64'd1);
        step();
        clrCnt = 1'b0;
        #1;
        chk("clr_pkt", 64'(pktCnt), 64'd0);
        drain("clr");
        chk("clr_pkt_after", 64'(pktCnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tlp_fifo_reader.md
TLP_FIFO_READER -- requirements
Module: tlp_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 256: payload width; FIFO word width is DATA_W+11.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have port clockCore, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetCore, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port fifoEmpty, input, 1 bit: the FIFO empty flag.
REQ-006 SHALL have port fifoData, input, DATA_W+11 bits: the FIFO head word, valid when fifoEmpty=0.
- Field layout: [DATA_W-1:0] data, [DATA_W+7:DATA_W] keep (dword enables), [DATA_W+8] sop, [DATA_W+9] eop, [DATA_W+10] err.
REQ-007 SHALL have port fifoPop, output, 1 bit: the FIFO pop strobe.
REQ-008 SHALL have ports outValid/outReady, output/input, 1 bit each: the downstream handshake.
REQ-009 SHALL have ports outData, outKeep, outSop, outEop and outErr, all outputs, with widths DATA_W, 8, 1, 1 and 1: the registered output beat.
REQ-010 SHALL have port enable, input, 1 bit: permits a new packet to start.
REQ-011 SHALL have port clrCnt, input, 1 bit: synchronous clear of all counters.
REQ-012 SHALL have ports pktCnt, dropCnt and errCnt, outputs, CNT_W bits each: the statistics counters.
REQ-013 SHALL have port orphanErr, output, 1 bit: one-cycle pulse on an orphan beat.
REQ-014 SHALL have port busy, output, 1 bit: high when state!=IDLE or outValid=1.

Function
REQ-015 SHALL use a one-entry output register; a beat is accepted downstream when outValid&outReady.
- Output stage "free" means: outValid=0, or outReady=1.
REQ-016 SHALL drive fifoPop combinationally, and never when fifoEmpty=1.
REQ-017 SHALL present a forwarded head word on outValid the cycle after its pop; latency 1, throughput 1 beat/cycle.
REQ-018 SHALL hold outValid and all out* fields stable while outValid=1 and outReady=0.
REQ-019 SHALL, in state IDLE, when fifoEmpty=0, enable=1, head sop=1 and the output stage is free:
- pop and forward the beat;
- go to PKT, or stay in IDLE if eop=1 (single-beat packet; pktCnt+1).
REQ-020 SHALL, in IDLE, when fifoEmpty=0 and head sop=0 (regardless of enable):
- pop without forwarding and pulse orphanErr;
- go to DROP if eop=0, else stay in IDLE;
- dropCnt+1.
REQ-021 SHALL, in PKT, when head sop=0 and the output stage is free:
- pop and forward the beat; enable is ignored;
- on eop=1, go to IDLE and pktCnt+1.
REQ-022 SHALL, in PKT, when head sop=1, not pop, and instead:
- load a synthetic terminator beat: outKeep=0, outData=0, outSop=0, outEop=1, outErr=1;
- errCnt+1, go to IDLE; the sop beat is then handled by REQ-019.
REQ-023 SHALL, in DROP, pop every cycle fifoEmpty=0 regardless of outReady, with no output, and return to IDLE on eop=1.
REQ-024 SHALL forward head err as outErr unchanged, with no state effect.
REQ-025 SHALL saturate every counter at all-ones; clrCnt=1 zeroes all counters, taking priority over a same-cycle increment.
REQ-026 SHALL, with enable=0 in IDLE, hold fifoPop=0 for sop beats; a packet already in flight completes.

Reset
REQ-027 SHALL, on resetCore=0, set asynchronously:
- state=IDLE;
- outValid=0; outData, outKeep, outSop, outEop, outErr all 0;
- all counters 0; orphanErr=0; busy=0; fifoPop=0.
REQ-028 SHALL abandon any partial packet on reset and resume in IDLE; no terminator beat is issued.

Structure
REQ-029 SHALL take from a shared package tlp_fifo_pkg:
- the state enum (IDLE, PKT, DROP);
- field offset constants SOP_BIT, EOP_BIT, ERR_BIT, KEEP_LSB;
- the sideband width constant, 11.
REQ-030 SHALL instantiate sub-module sat_cnt (parameter CNT_W; inputs inc, clr) three times, once per counter.

Verification
REQ-031 SHALL cover the single-beat packet case.
- Stimulus: head {sop=1, eop=1, keep=8'hFF, data=A}, outReady=1.
- Response: one-cycle fifoPop; outValid the next cycle with data A; pktCnt=1.
REQ-032 SHALL cover back-pressure on a 4-beat packet.
- Stimulus: 4-beat packet, outReady=0 for 3 cycles after beat 2.
- Response: beat 2 held stable; no pop while stalled; 4 beats in order; pktCnt=1.
REQ-033 SHALL cover an orphan packet.
- Stimulus: 3 beats with sop=0, eop on the 3rd.
- Response: orphanErr pulse on beat 1; all 3 popped with outReady=0; no outValid; dropCnt=1; state IDLE.
REQ-034 SHALL cover a truncated packet.
- Stimulus: sop, mid, then a new sop+eop beat.
- Response: terminator beat (keep=0, eop=1, err=1); errCnt=1; then the new packet forwarded; pktCnt=1.
REQ-035 SHALL cover enable gating.
- Stimulus: enable=0 with a sop beat queued.
- Response: no pop.
- Then: enable falls mid-packet; the packet completes through eop.
REQ-036 SHALL cover counter saturation and clear.
- Stimulus: CNT_W=2, 5 packets.
- Response: pktCnt=3.
- Then: clrCnt with a simultaneous eop; pktCnt=0.
